// File: rtl/frame_strobe_driver.sv
// -----------------------------------------------------------------------------
// frame_strobe_driver
//
// Column configuration driver. Takes a stream of 32-bit configuration words,
// assembles one frame of FrameData (one 32-bit slice per row of the column),
// then drives a one-hot FrameStrobe pulse. FrameData is stable for one cycle
// before the strobe rises (SETUP) and for one cycle after it falls (HOLD).
//
// Word stream format:
//   header : cfg_data[31:24] == 8'hF5, cfg_data[7:0] == frame index
//   rows   : the next NumRows accepted words, row 0 first, no marker check
//
// Handshake: a word transfers on a rising edge of UserCLK where
// cfg_valid && cfg_ready are both high. cfg_ready is a registered function of
// the state only (high in IDLE and LOAD), so it never depends on cfg_valid in
// the same cycle. The producer may drop cfg_valid at any time; a gap in LOAD
// simply stalls the row counter.
//
// Ports:
//   UserCLK      in   clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   cfg_valid    in   input word valid
//   cfg_ready    out  block can accept a word
//   cfg_data     in   header or row data word
//   FrameData    out  assembled frame, row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  out  one-hot write strobe, all-zero outside STROBE
//   busy         out  high in any state except IDLE
//   frame_done   out  one-cycle pulse (HOLD) when a frame has been written
//   err_index    out  sticky: a header carried an out-of-range frame index
//   frame_count  out  frames written, saturating at 16'hFFFF
//   dbg_state    out  current FSM state encoding (debug / checker hook)
// -----------------------------------------------------------------------------
module frame_strobe_driver #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                 UserCLK,
    input  logic                                 reset,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [31:0]                          cfg_data,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 err_index,
    output logic [15:0]                          frame_count,
    output logic [2:0]                           dbg_state
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);
    localparam logic [7:0] HDR_MARKER = 8'hF5;
    // Frame limit widened by one bit so an 8-bit index compares without
    // truncation even when MaxFramesPerCol is 256.
    localparam logic [8:0] NUM_FRAMES = 9'(MaxFramesPerCol);
    // Down-counter preload: the strobe lasts while the counter walks
    // StrobeCycles-1 .. 0.
    localparam logic [3:0] STROBE_LOAD = 4'(StrobeCycles - 1);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                               r_state;
    logic                                 r_cfg_ready;
    logic [FrameBitsPerRow*NumRows-1:0]   r_frame_data;
    logic [MaxFramesPerCol-1:0]           r_frame_strobe;
    logic                                 r_busy;
    logic                                 r_frame_done;
    logic                                 r_err_index;
    logic [15:0]                          r_frame_count;
    logic [7:0]                           r_index;
    logic [ROW_W-1:0]                     r_row;
    logic [3:0]                           r_strobe_cnt;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                          w_accept;
    logic                          w_is_header;
    logic                          w_hdr_in_range;
    logic                          w_idx_in_range;
    logic [MaxFramesPerCol-1:0]    w_strobe_pattern;
    logic [15:0]                   w_count_next;

    assign w_accept         = cfg_valid && r_cfg_ready;
    assign w_is_header      = (cfg_data[31:24] == HDR_MARKER);
    assign w_hdr_in_range   = ({1'b0, cfg_data[7:0]} < NUM_FRAMES);
    assign w_idx_in_range   = ({1'b0, r_index} < NUM_FRAMES);
    // Only used when r_index is known to be in range, so the shift never
    // walks the bit off the end of the strobe vector.
    assign w_strobe_pattern = STROBE_ONE << r_index;
    assign w_count_next     = (r_frame_count == 16'hFFFF) ? r_frame_count
                                                          : r_frame_count + 16'd1;

    // -------------------------------------------------------------------------
    // Main FSM. Every output is a register updated on the state transition
    // that enters the state in which it must be visible.
    // -------------------------------------------------------------------------
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cfg_ready    <= 1'b1;
            r_frame_data   <= '0;
            r_frame_strobe <= '0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_index    <= 1'b0;
            r_frame_count  <= 16'd0;
            r_index        <= 8'd0;
            r_row          <= '0;
            r_strobe_cnt   <= 4'd0;
        end else begin
            // frame_done is a single-cycle pulse; it is only raised on the
            // STROBE -> HOLD transition below.
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Non-header words are accepted and dropped.
                    if (w_accept && w_is_header) begin
                        r_index <= cfg_data[7:0];
                        r_row   <= '0;
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        if (!w_hdr_in_range) begin
                            r_err_index <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        // Rows are written even for a bad index, so the
                        // column sees the data but never a strobe for it.
                        r_frame_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
                        if (r_row == LAST_ROW) begin
                            if (w_idx_in_range) begin
                                r_state     <= S_SETUP;
                                r_cfg_ready <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end

                S_SETUP: begin
                    // One cycle of data setup before the strobe rises.
                    r_state        <= S_STROBE;
                    r_frame_strobe <= w_strobe_pattern;
                    r_strobe_cnt   <= STROBE_LOAD;
                end

                S_STROBE: begin
                    if (r_strobe_cnt == 4'd0) begin
                        r_state        <= S_HOLD;
                        r_frame_strobe <= '0;
                        r_frame_done   <= 1'b1;
                        r_frame_count  <= w_count_next;
                    end else begin
                        r_strobe_cnt <= r_strobe_cnt - 4'd1;
                    end
                end

                S_HOLD: begin
                    // One cycle of data hold after the strobe falls.
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_frame_strobe <= '0;
                    r_busy         <= 1'b0;
                    r_cfg_ready    <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg_ready   = r_cfg_ready;
    assign FrameData   = r_frame_data;
    assign FrameStrobe = r_frame_strobe;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err_index   = r_err_index;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_strobe_driver.sv
// -----------------------------------------------------------------------------
// tb_frame_strobe_driver
//
// Directed bench for frame_strobe_driver. Driver tasks push the expected
// result of every in-range frame ({frame_count, FrameStrobe, FrameData}) onto
// exp_q; an independent monitor pops and compares on each frame_done and also
// checks strobe value, start cycle and pulse length.
// -----------------------------------------------------------------------------
module tb_frame_strobe_driver;

    localparam int NF = 20;
    localparam int NR = 4;
    localparam int SC = 2;
    localparam int DW = 32 * NR;
    localparam int RW = 16 + NF + DW;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [31:0]     cfg_data;
    logic [DW-1:0]   FrameData;
    logic [NF-1:0]   FrameStrobe;
    logic            busy;
    logic            frame_done;
    logic            err_index;
    logic [15:0]     frame_count;
    logic [2:0]      dbg_state;

    frame_strobe_driver #(
        .MaxFramesPerCol (NF),
        .FrameBitsPerRow (32),
        .NumRows         (NR),
        .StrobeCycles    (SC)
    ) dut (
        .UserCLK     (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_index   (err_index),
        .frame_count (frame_count),
        .dbg_state   (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Bench state
    // -------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;

    logic [RW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    logic [15:0]   exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (entered and left just after a falling edge)
    // -------------------------------------------------------------------------
    task automatic send_word(input logic [31:0] d);
        cfg_data  = d;
        cfg_valid = 1'b1;
        for (int t = 0; t < 50 && !cfg_ready; t++) @(negedge clk);
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
            cfg_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Sends header + NR rows. gap_after >= 0 inserts gap_len idle cycles
    // after that row, checking the block stays in LOAD and ready.
    task automatic send_frame(input logic [7:0] idx,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input int gap_after, input int gap_len);
        logic [31:0] rows [NR];
        logic [NF-1:0] one;
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        send_word({8'hF5, 16'h0000, idx});
        for (int k = 0; k < NR; k++) begin
            send_word(rows[k]);
            exp_data[k*32 +: 32] = rows[k];
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    check("gap_ready", cfg_ready, 1'b1);
                    check("gap_busy", busy, 1'b1);
                    @(negedge clk);
                end
            end
        end
        if (idx < NF) begin
            exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
            one = NF'(1);
            exp_q.push_back({exp_cnt, one << idx, exp_data});
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    bit            in_pulse = 1'b0;
    int            plen = 0;
    logic [NF-1:0] pval;
    logic [RW-1:0] rec;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_pulse = 1'b0;
        end else begin
            if (FrameStrobe != '0) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    plen = 1;
                    pval = FrameStrobe;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe_unexpected actual=%h required=0", FrameStrobe);
                    end else begin
                        rec = exp_q[0];
                        check("strobe_value", FrameStrobe, rec[DW +: NF]);
                        check("strobe_start_cycle", cyc, last_acc + 2);
                    end
                end else begin
                    plen++;
                    check("strobe_stable", FrameStrobe, pval);
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check("strobe_length", plen, SC);
            end

            if (frame_done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    rec = exp_q.pop_front();
                    check("done_frame_data", FrameData, rec[DW-1:0]);
                    check("done_frame_count", frame_count, rec[DW+NF +: 16]);
                end
            end
        end
    end

    // Hard stop so a wedged run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 32'h0;
        exp_data  = '0;
        exp_cnt   = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Reset values
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_data", FrameData, '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_err", err_index, 1'b0);
        check("rst_count", frame_count, 16'd0);

        // 1: basic frame, index 3, back-to-back rows
        send_frame(8'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, -1, 0);
        repeat (5) @(negedge clk);
        check("t1_data", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("t1_count", frame_count, 16'd1);
        check("t1_idle_ready", cfg_ready, 1'b1);
        check("t1_idle_busy", busy, 1'b0);

        // 2: out-of-range index 20
        send_frame(8'd20, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, -1, 0);
        check("t2_ready_after_row4", cfg_ready, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_err", err_index, 1'b1);
        check("t2_data_written", FrameData, exp_data);
        for (int i = 0; i < 6; i++) begin
            check("t2_no_strobe", FrameStrobe, '0);
            check("t2_no_done", frame_done, 1'b0);
            @(negedge clk);
        end
        check("t2_count", frame_count, 16'd1);

        // 3: non-header words in IDLE are accepted and dropped
        check("t3_ready_a", cfg_ready, 1'b1);
        send_word(32'h12345678);
        check("t3_state_a", dbg_state, 3'd0);
        check("t3_data_a", FrameData, exp_data);
        check("t3_ready_b", cfg_ready, 1'b1);
        send_word(32'h00000000);
        check("t3_state_b", dbg_state, 3'd0);
        check("t3_busy_b", busy, 1'b0);
        check("t3_data_b", FrameData, exp_data);

        // 4: index 19 with a 3-cycle valid gap between rows 1 and 2
        send_frame(8'd19, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 1, 3);
        check("t4_ready_setup", cfg_ready, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t4_ready_busy_phase", cfg_ready, 1'b0);
            if (i == 1) check("t4_strobe_idx19", FrameStrobe, 20'h80000);
        end
        @(negedge clk);
        check("t4_ready_idle", cfg_ready, 1'b1);
        check("t4_data", FrameData, 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF);

        // 5: reset during the first STROBE cycle
        send_frame(8'd5, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, -1, 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_strobe_drop", FrameStrobe, '0);
        check("t5_data", FrameData, '0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", frame_done, 1'b0);
        check("t5_err", err_index, 1'b0);
        check("t5_count", frame_count, 16'd0);
        check("t5_ready", cfg_ready, 1'b1);
        reset    = 1'b0;
        exp_data = '0;
        exp_cnt  = 16'd0;
        @(negedge clk);
        mon_en = 1'b1;
        send_frame(8'd0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13579BDF, 32'h2468ACE0, -1, 0);
        repeat (5) @(negedge clk);
        check("t5_fresh_count", frame_count, 16'd1);

        // 6: saturation of frame_count
        force dut.r_frame_count = 16'hFFFE;
        #1;
        release dut.r_frame_count;
        @(negedge clk);
        check("t6_preload", frame_count, 16'hFFFE);
        exp_cnt = 16'hFFFE;
        send_frame(8'd7, 32'h1, 32'h2, 32'h3, 32'h4, -1, 0);
        repeat (5) @(negedge clk);
        check("t6_count_first", frame_count, 16'hFFFF);
        send_frame(8'd8, 32'h5, 32'h6, 32'h7, 32'h8, -1, 0);
        repeat (5) @(negedge clk);
        check("t6_count_second", frame_count, 16'hFFFF);

        check("frames_done_total", done_seen, 5);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
